// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared definitions for the RAM read-port arbiter. It holds
//                the client-count ceiling, the client index type and the
//                wrapping round-robin increment used by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

   localparam int MAX_REQ = 8;

   // Index type wide enough for any client number up to MAX_REQ-1.
   typedef logic [2:0] req_idx_t;

   // Advance a client index by one, wrapping back to 0 after client n-1.
   function automatic req_idx_t rr_next(input req_idx_t ptr, input int n);
      if (int'(ptr) >= n - 1) begin
         return '0;
      end
      return ptr + req_idx_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. It grants the first set
//                request bit at or above ptr, searching upward and wrapping.
//  Ports       : req   - request vector, one bit per client
//                ptr   - client that has the highest priority this cycle
//                grant - one-hot grant, all zero when nothing requests
//                idx   - encoded grant index, 0 when nothing requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_t           ptr,
   output logic [NUM_REQ-1:0] grant,
   output req_idx_t           idx
);

   // The search runs from the farthest offset back to offset 0. A later
   // assignment overrides an earlier one, so the requester closest to ptr wins.
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      j     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = req_idx_t'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rd_arbiter
//  Description : Round-robin arbiter that shares the read port of a 1R1W
//                backpressured RAM among num_req_p clients. It routes each
//                one-cycle-latency response to the client that issued the
//                request. Response backpressure reaches the RAM unchanged.
//  Ports       : clk, rst            - clock, async active-high reset
//                cl_rd_req_*         - per-client read request channel
//                cl_rd_resp_*        - per-client read response channel
//                ram_rd_req_*        - RAM read request channel
//                ram_rd_resp_*       - RAM read response channel
//                stat_clr,
//                stat_grant_cnt      - grant counters (RAM_RD_ARB_STATS_EN)
//  Options     : define RAM_RD_ARB_STATS_EN to build the per-client
//                saturating grant counters
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_arbiter
   import ram_arb_pkg::*;
#(
   parameter int num_req_p = 2,
   parameter int addr_w_p  = 8,
   parameter int width_p   = 64,
   parameter int cnt_w_p   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [num_req_p-1:0]          cl_rd_req_val,
   input  logic [num_req_p*addr_w_p-1:0] cl_rd_req_addr,
   output logic [num_req_p-1:0]          cl_rd_req_rdy,
   output logic [num_req_p-1:0]          cl_rd_resp_val,
   output logic [width_p-1:0]            cl_rd_resp_data,
   input  logic [num_req_p-1:0]          cl_rd_resp_rdy,
   output logic                          ram_rd_req_val,
   output logic [addr_w_p-1:0]           ram_rd_req_addr,
   input  logic                          ram_rd_req_rdy,
   input  logic                          ram_rd_resp_val,
   input  logic [width_p-1:0]            ram_rd_resp_data,
   output logic                          ram_rd_resp_rdy
`ifdef RAM_RD_ARB_STATS_EN
   ,
   input  logic                          stat_clr,
   output logic [num_req_p*cnt_w_p-1:0]  stat_grant_cnt
`endif
);

   localparam int PTR_W = $clog2(num_req_p);

   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     owner_q;
   logic [num_req_p-1:0] w_grant;
   req_idx_t             w_win_idx;
   logic                 w_req_hs;

   rr_pick #(
      .NUM_REQ (num_req_p)
   ) u_rr_pick (
      .req   (cl_rd_req_val),
      .ptr   (req_idx_t'(rr_ptr)),
      .grant (w_grant),
      .idx   (w_win_idx)
   );

   // ------------------------------------------------------------------
   // Request side: pass the winner through with no added latency.
   // ------------------------------------------------------------------
   assign ram_rd_req_val  = |cl_rd_req_val;
   assign ram_rd_req_addr = cl_rd_req_addr[w_win_idx*addr_w_p +: addr_w_p];
   assign cl_rd_req_rdy   = w_grant & {num_req_p{ram_rd_req_rdy}};
   assign w_req_hs        = ram_rd_req_val & ram_rd_req_rdy;

   // The RAM holds at most one response. Its response register updates only
   // while ram_rd_req_rdy is high. A handshake therefore always retires the
   // previous response, so a single owner tag is enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         owner_q <= '0;
      end else if (w_req_hs) begin
         rr_ptr  <= PTR_W'(rr_next(w_win_idx, num_req_p));
         owner_q <= PTR_W'(w_win_idx);
      end
   end

   // ------------------------------------------------------------------
   // Response side: steer valid to the owner, take ready only from it.
   // ------------------------------------------------------------------
   always_comb begin
      cl_rd_resp_val          = '0;
      cl_rd_resp_val[owner_q] = ram_rd_resp_val;
   end

   assign cl_rd_resp_data = ram_rd_resp_data;
   assign ram_rd_resp_rdy = cl_rd_resp_rdy[owner_q];

`ifdef RAM_RD_ARB_STATS_EN
   // ------------------------------------------------------------------
   // Saturating per-client grant counters. A clear wins over an increment.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < num_req_p; i++) begin : g_grant_cnt
      logic [cnt_w_p-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (stat_clr) begin
            r_cnt <= '0;
         end else if (cl_rd_req_rdy[i] && !(&r_cnt)) begin
            r_cnt <= r_cnt + cnt_w_p'(1);
         end
      end

      assign stat_grant_cnt[i*cnt_w_p +: cnt_w_p] = r_cnt;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_rd_arbiter
//  Description : Self-checking bench for ram_rd_arbiter with three clients.
//                A small RAM model sits behind the arbiter. The bench runs a
//                vector table, hand-written corner sequences and a random
//                phase checked against a behavioural model.
//  Options     : RAM_RD_ARB_STATS_EN adds the grant-counter sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rd_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    cl_rd_req_val = '0;
   logic [N*AW-1:0] cl_rd_req_addr;
   logic [N-1:0]    cl_rd_req_rdy;
   logic [N-1:0]    cl_rd_resp_val;
   logic [DW-1:0]   cl_rd_resp_data;
   logic [N-1:0]    cl_rd_resp_rdy = '1;
   logic            ram_rd_req_val;
   logic [AW-1:0]   ram_rd_req_addr;
   logic            ram_rd_req_rdy;
   logic            ram_rd_resp_val;
   logic [DW-1:0]   ram_rd_resp_data;
   logic            ram_rd_resp_rdy;
`ifdef RAM_RD_ARB_STATS_EN
   logic            stat_clr = 1'b0;
   logic [N*CW-1:0] stat_grant_cnt;
`endif

   logic [AW-1:0] addr [N];
   logic [DW-1:0] mem [256];

   int total = 0;
   int bad   = 0;

   assign cl_rd_req_addr = {addr[2], addr[1], addr[0]};

   always #5 clk = ~clk;

   ram_rd_arbiter #(
      .num_req_p (N),
      .addr_w_p  (AW),
      .width_p   (DW),
      .cnt_w_p   (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cl_rd_req_val    (cl_rd_req_val),
      .cl_rd_req_addr   (cl_rd_req_addr),
      .cl_rd_req_rdy    (cl_rd_req_rdy),
      .cl_rd_resp_val   (cl_rd_resp_val),
      .cl_rd_resp_data  (cl_rd_resp_data),
      .cl_rd_resp_rdy   (cl_rd_resp_rdy),
      .ram_rd_req_val   (ram_rd_req_val),
      .ram_rd_req_addr  (ram_rd_req_addr),
      .ram_rd_req_rdy   (ram_rd_req_rdy),
      .ram_rd_resp_val  (ram_rd_resp_val),
      .ram_rd_resp_data (ram_rd_resp_data),
      .ram_rd_resp_rdy  (ram_rd_resp_rdy)
`ifdef RAM_RD_ARB_STATS_EN
      ,
      .stat_clr         (stat_clr),
      .stat_grant_cnt   (stat_grant_cnt)
`endif
   );

   // RAM model: one-cycle read latency. The response register holds while
   // the response is stalled, and the RAM is ready only when it can accept
   // a new read.
   logic          ram_resp_val_q;
   logic [DW-1:0] ram_resp_data_q;

   assign ram_rd_req_rdy   = !(ram_resp_val_q && !ram_rd_resp_rdy);
   assign ram_rd_resp_val  = ram_resp_val_q;
   assign ram_rd_resp_data = ram_resp_data_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_resp_val_q  <= 1'b0;
         ram_resp_data_q <= '0;
      end else if (ram_rd_req_rdy) begin
         ram_resp_val_q  <= ram_rd_req_val;
         ram_resp_data_q <= mem[ram_rd_req_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      cl_rd_req_val  = '0;
      cl_rd_resp_rdy = '1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  resp_rdy;
      logic [N-1:0]  exp_req_rdy;
      logic [N-1:0]  exp_resp_val;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vec [14];

   // Behavioural model state for the random phase.
   int            m_ptr;
   bit            m_pend;
   int            m_owner;
   logic [DW-1:0] m_data;

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 64'h1000 + 64'(a);
      mem[5] = 64'hAA;
      addr[0] = 8'h12;
      addr[1] = 8'h05;
      addr[2] = 8'h20;

      // Rotation, routing of address 0x05, idle, then a 3-cycle response hold.
      vec[0]  = '{3'b111, 3'b111, 3'b001, 3'b000, 64'h0};
      vec[1]  = '{3'b111, 3'b111, 3'b010, 3'b001, 64'h1012};
      vec[2]  = '{3'b111, 3'b111, 3'b100, 3'b010, 64'hAA};
      vec[3]  = '{3'b111, 3'b111, 3'b001, 3'b100, 64'h1020};
      vec[4]  = '{3'b111, 3'b111, 3'b010, 3'b001, 64'h1012};
      vec[5]  = '{3'b111, 3'b111, 3'b100, 3'b010, 64'hAA};
      vec[6]  = '{3'b000, 3'b111, 3'b000, 3'b100, 64'h1020};
      vec[7]  = '{3'b000, 3'b111, 3'b000, 3'b000, 64'h0};
      vec[8]  = '{3'b001, 3'b111, 3'b001, 3'b000, 64'h0};
      vec[9]  = '{3'b100, 3'b110, 3'b000, 3'b001, 64'h1012};
      vec[10] = '{3'b100, 3'b110, 3'b000, 3'b001, 64'h1012};
      vec[11] = '{3'b100, 3'b110, 3'b000, 3'b001, 64'h1012};
      vec[12] = '{3'b100, 3'b111, 3'b100, 3'b001, 64'h1012};
      vec[13] = '{3'b000, 3'b111, 3'b000, 3'b100, 64'h1020};

      do_reset();
      check("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      check("reset_owner", 64'(dut.owner_q), 64'd0);
      check("reset_resp_val", 64'(cl_rd_resp_val), 64'd0);

      for (int i = 0; i < 14; i++) begin
         cl_rd_req_val  = vec[i].req;
         cl_rd_resp_rdy = vec[i].resp_rdy;
         #1;
         check($sformatf("tbl%0d_req_rdy", i), 64'(cl_rd_req_rdy), 64'(vec[i].exp_req_rdy));
         check($sformatf("tbl%0d_ram_val", i), 64'(ram_rd_req_val), 64'(|vec[i].req));
         check($sformatf("tbl%0d_resp_val", i), 64'(cl_rd_resp_val), 64'(vec[i].exp_resp_val));
         if (vec[i].exp_resp_val != 0)
            check($sformatf("tbl%0d_data", i), cl_rd_resp_data, vec[i].exp_data);
         @(negedge clk);
      end

      // Single requester: client 2 wins four cycles back to back.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         addr[2]        = 8'h30 + 8'(k);
         cl_rd_req_val  = (k < 4) ? 3'b100 : 3'b000;
         cl_rd_resp_rdy = 3'b111;
         #1;
         check("single_req_rdy", 64'(cl_rd_req_rdy), (k < 4) ? 64'b100 : 64'b000);
         if (k > 0) begin
            check("single_resp_val", 64'(cl_rd_resp_val), 64'b100);
            check("single_data", cl_rd_resp_data, 64'h1000 + 64'h30 + 64'(k - 1));
         end
         @(posedge clk);
         #1;
         if (k < 4) check("single_ptr_wrap", 64'(dut.rr_ptr), 64'd0);
         @(negedge clk);
      end
      addr[2] = 8'h20;

      // Asynchronous reset with rr_ptr at 2.
      do_reset();
      cl_rd_req_val = 3'b111;
      #1 check("arst_g0", 64'(cl_rd_req_rdy), 64'b001);
      @(negedge clk);
      #1 check("arst_g1", 64'(cl_rd_req_rdy), 64'b010);
      @(negedge clk);
      check("arst_ptr_before", 64'(dut.rr_ptr), 64'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_ptr_cleared", 64'(dut.rr_ptr), 64'd0);
      check("arst_resp_dropped", 64'(cl_rd_resp_val), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("arst_first_win", 64'(cl_rd_req_rdy), 64'b001);
      @(negedge clk);

`ifdef RAM_RD_ARB_STATS_EN
      // Stats: five grants to client 1, then a clear in a granting cycle.
      do_reset();
      cl_rd_req_val = 3'b010;
      for (int k = 0; k < 5; k++) @(negedge clk);
      check("stat_cnt5", 64'(stat_grant_cnt[CW +: CW]), 64'd5);
      check("stat_cnt0_idle", 64'(stat_grant_cnt[0 +: CW]), 64'd0);
      stat_clr = 1'b1;
      #1 check("stat_clr_grant", 64'(cl_rd_req_rdy), 64'b010);
      @(negedge clk);
      stat_clr      = 1'b0;
      cl_rd_req_val = 3'b000;
      check("stat_cleared", 64'(stat_grant_cnt[CW +: CW]), 64'd0);
      @(negedge clk);
`endif

      // Random phase against the behavioural model.
      do_reset();
      m_ptr   = 0;
      m_pend  = 0;
      m_owner = 0;
      m_data  = '0;
      for (int c = 0; c < 500; c++) begin
         int            win;
         bit            exp_rdy;
         logic [N-1:0]  rr;
         logic [N-1:0]  req;
         req = 3'($urandom_range(0, 7));
         for (int i = 0; i < N; i++) begin
            addr[i] = 8'($urandom_range(0, 255));
            rr[i]   = ($urandom_range(0, 3) != 0);
         end
         cl_rd_req_val  = req;
         cl_rd_resp_rdy = rr;
         #1;
         exp_rdy = !(m_pend && !rr[m_owner]);
         win     = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && win < 0) win = j;
         end
         check("rnd_req_rdy", 64'(cl_rd_req_rdy), (win >= 0 && exp_rdy) ? (64'd1 << win) : 64'd0);
         check("rnd_ram_val", 64'(ram_rd_req_val), 64'(win >= 0));
         if (win >= 0) check("rnd_ram_addr", 64'(ram_rd_req_addr), 64'(addr[win]));
         check("rnd_resp_val", 64'(cl_rd_resp_val), m_pend ? (64'd1 << m_owner) : 64'd0);
         if (m_pend) check("rnd_resp_data", cl_rd_resp_data, m_data);
         check("rnd_resp_rdy", 64'(ram_rd_resp_rdy), 64'(rr[m_owner]));
         if (exp_rdy) begin
            if (win >= 0) begin
               m_ptr   = (win + 1) % N;
               m_owner = win;
               m_data  = mem[addr[win]];
            end
            m_pend = (win >= 0);
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
